// File: rtl/xalu_pkg.sv
// xalu_pkg: shared definitions for the HI/LO multiply/divide sequencer.
//   - op encodings for mult/multu/div/divu
//   - FSM state enum
//   - default busy latencies
//   - divide-by-zero result constants
package xalu_pkg;

  localparam logic [1:0] OP_MULTU = 2'd0;
  localparam logic [1:0] OP_MULT  = 2'd1;
  localparam logic [1:0] OP_DIVU  = 2'd2;
  localparam logic [1:0] OP_DIV   = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } xalu_state_t;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // Divide by zero: LO is all ones, HI takes the dividend.
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/xalu_arith.sv
// xalu_arith: combinational result generator, {res_hi, res_lo} = f(op, a, b).
// Ports:
//   op      in  2   operation (OP_MULTU/OP_MULT/OP_DIVU/OP_DIV)
//   a, b    in  32  rs / rt operands
//   res_hi  out 32  HI result (product upper half / remainder)
//   res_lo  out 32  LO result (product lower half / quotient)
module xalu_arith
  import xalu_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0]        uprod;
  logic signed [63:0] sprod;
  logic               div_zero;
  logic               div_ovf;
  logic [31:0]        b_safe;
  logic signed [31:0] sa;
  logic signed [31:0] sb;
  logic signed [31:0] sq;
  logic signed [31:0] sr;
  logic [31:0]        uq;
  logic [31:0]        ur;

  assign uprod = {32'd0, a} * {32'd0, b};
  assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

  assign div_zero = (b == 32'd0);
  // Most-negative / -1 overflows a 32-bit quotient; handled explicitly below.
  assign div_ovf  = (op == OP_DIV) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // Keep the divider's divisor out of the zero/overflow cases; those results are substituted.
  assign b_safe = (div_zero || div_ovf) ? 32'd1 : b;
  assign sa     = $signed(a);
  assign sb     = $signed(b_safe);
  assign sq     = sa / sb;
  assign sr     = sa % sb;
  assign uq     = a / b_safe;
  assign ur     = a % b_safe;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      OP_MULTU: begin
        res_hi = uprod[63:32];
        res_lo = uprod[31:0];
      end
      OP_MULT: begin
        res_hi = sprod[63:32];
        res_lo = sprod[31:0];
      end
      OP_DIVU: begin
        if (div_zero) begin
          res_hi = a;
          res_lo = DIV0_LO;
        end else begin
          res_hi = ur;
          res_lo = uq;
        end
      end
      default: begin
        if (div_zero) begin
          res_hi = a;
          res_lo = DIV0_LO;
        end else if (div_ovf) begin
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else begin
          res_hi = sr;
          res_lo = sq;
        end
      end
    endcase
  end

endmodule

// File: rtl/xalu_seq.sv
// xalu_seq: multi-cycle mult/div sequencer owning the HI/LO register pair.
// Optional feature macro: XALU_CANCEL_EN (adds the cancel port for flushes).
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start, op, a, b E-stage mult/div request and operands
//   we, hilo        E-stage mthi (hilo=1) / mtlo (hilo=0) write of a
//   outsel          mfhi (1) / mflo (0) read select
//   d_hilo_use      D stage holds a HI/LO-touching instruction
//   cancel          abort in-flight op (XALU_CANCEL_EN only)
//   busy, stall     operation in flight / D-stage stall request
//   out, hi, lo     read data and architectural HI/LO
//
// state | meaning
// IDLE  | no op in flight; accepts start or mthi/mtlo
// BUSY  | counting down; commits pending result when cnt == 1
module xalu_seq
  import xalu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        we,
  input  logic        hilo,
  input  logic        outsel,
  input  logic        d_hilo_use,
`ifdef XALU_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic        stall,
  output logic [31:0] out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  xalu_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       pend_hi;
  logic [31:0]       pend_lo;
  logic [31:0]       res_hi;
  logic [31:0]       res_lo;
  logic              cancel_i;

`ifdef XALU_CANCEL_EN
  assign cancel_i = cancel;
`else
  assign cancel_i = 1'b0;
`endif

  xalu_arith u_arith (
    .op     (op),
    .a      (a),
    .b      (b),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !cancel_i) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            cnt     <= op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state   <= BUSY;
            busy    <= 1'b1;
          end else if (we && !start) begin
            // A start in the same cycle (even one dropped by cancel) suppresses the write.
            if (hilo) hi <= a;
            else      lo <= a;
          end
        end
        BUSY: begin
          if (cancel_i) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == CNT_W'(1)) begin
            hi    <= pend_hi;
            lo    <= pend_lo;
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign stall = d_hilo_use & (start | busy);
  assign out   = outsel ? hi : lo;

endmodule

// File: tb/tb_xalu_seq.sv
// tb_xalu_seq: directed-vector bench for xalu_seq with hand-computed results.
// Inputs change on the falling edge; outputs are checked away from the rising edge.
module tb_xalu_seq;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        we;
  logic        hilo;
  logic        outsel;
  logic        d_hilo_use;
`ifdef XALU_CANCEL_EN
  logic        cancel;
`endif
  logic        busy;
  logic        stall;
  logic [31:0] out;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  xalu_seq #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .we         (we),
    .hilo       (hilo),
    .outsel     (outsel),
    .d_hilo_use (d_hilo_use),
`ifdef XALU_CANCEL_EN
    .cancel     (cancel),
`endif
    .busy       (busy),
    .stall      (stall),
    .out        (out),
    .hi         (hi),
    .lo         (lo)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op at the current falling edge (cycle 0) with d_hilo_use held,
  // check busy/stall in cycles 0..n, then HI/LO and released stall in cycle n+1.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input int n,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    start = 1'b1; op = o; a = x; b = y; d_hilo_use = 1'b1;
    #1;
    chk({tag, " stall c0"}, {31'd0, stall}, 32'd1);
    chk({tag, " busy c0"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0; a = 32'h0; b = 32'h0;
    for (int i = 1; i <= n; i++) begin
      chk($sformatf("%s busy c%0d", tag, i), {31'd0, busy}, 32'd1);
      chk($sformatf("%s stall c%0d", tag, i), {31'd0, stall}, 32'd1);
      @(negedge clk);
    end
    chk({tag, " busy done"}, {31'd0, busy}, 32'd0);
    chk({tag, " stall done"}, {31'd0, stall}, 32'd0);
    chk({tag, " hi"}, hi, exp_hi);
    chk({tag, " lo"}, lo, exp_lo);
    d_hilo_use = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'd0; a = 32'h0; b = 32'h0;
    we = 1'b0; hilo = 1'b0; outsel = 1'b0; d_hilo_use = 1'b0;
`ifdef XALU_CANCEL_EN
    cancel = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    chk("rst out", out, 32'd0);
    chk("rst stall", {31'd0, stall}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Back-to-back: each do_op starts in the cycle the previous one freed.
    do_op("mult",      2'd1, 32'hFFFF_FFFD, 32'd5,          MC, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    do_op("multu",     2'd0, 32'hFFFF_FFFF, 32'd2,          MC, 32'h0000_0001, 32'hFFFF_FFFE);
    do_op("div",       2'd3, 32'hFFFF_FFF9, 32'd2,          DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("divu0",     2'd2, 32'h0000_1234, 32'd0,          DC, 32'h0000_1234, 32'hFFFF_FFFF);
    do_op("div ovf",   2'd3, 32'h8000_0000, 32'hFFFF_FFFF,  DC, 32'h0000_0000, 32'h8000_0000);
    do_op("div0",      2'd3, 32'hFFFF_FFF9, 32'd0,          DC, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    do_op("divu",      2'd2, 32'd100,       32'd7,          DC, 32'd2,         32'd14);
    do_op("div negb",  2'd3, 32'd7,         32'hFFFF_FFFE,  DC, 32'd1,         32'hFFFF_FFFD);

    // mthi and a second start while busy must both be ignored.
    start = 1'b1; op = 2'd0; a = 32'd2; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    we = 1'b1; hilo = 1'b1; a = 32'hAAAA_0000;
    @(negedge clk);
    we = 1'b0; start = 1'b1; op = 2'd0; a = 32'd100; b = 32'd100;
    @(negedge clk);
    start = 1'b0;
    repeat (MC - 3) @(negedge clk);
    chk("busy wr idle", {31'd0, busy}, 32'd0);
    chk("busy wr hi", hi, 32'd0);
    chk("busy wr lo", lo, 32'd6);

    // mthi in IDLE: no same-cycle bypass, visible next cycle.
    we = 1'b1; hilo = 1'b1; a = 32'hAAAA_0000; outsel = 1'b1;
    #1;
    chk("mthi no bypass", out, 32'd0);
    @(negedge clk);
    we = 1'b0;
    chk("mthi out", out, 32'hAAAA_0000);
    we = 1'b1; hilo = 1'b0; a = 32'h0000_5555; outsel = 1'b0;
    @(negedge clk);
    we = 1'b0;
    chk("mtlo out", out, 32'h0000_5555);
    chk("mtlo hi kept", hi, 32'hAAAA_0000);

    // start and we together: start wins, LO gets the product rather than a.
    start = 1'b1; we = 1'b1; hilo = 1'b0; op = 2'd0; a = 32'd9; b = 32'd4;
    @(negedge clk);
    start = 1'b0; we = 1'b0;
    chk("st+we lo kept", lo, 32'h0000_5555);
    repeat (MC) @(negedge clk);
    chk("st+we lo", lo, 32'd36);
    chk("st+we hi", hi, 32'd0);

    // Reset in cycle 3 of a mult.
    we = 1'b1; hilo = 1'b1; a = 32'h1111_1111;
    @(negedge clk);
    we = 1'b0;
    start = 1'b1; op = 2'd1; a = 32'd7; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre rst busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid rst busy", {31'd0, busy}, 32'd0);
    chk("mid rst hi", hi, 32'd0);
    chk("mid rst lo", lo, 32'd0);
    repeat (MC) @(negedge clk);
    chk("mid rst no commit", lo, 32'd0);

`ifdef XALU_CANCEL_EN
    we = 1'b1; hilo = 1'b1; a = 32'hCAFE_0001;
    @(negedge clk);
    we = 1'b0;
    start = 1'b1; op = 2'd3; a = 32'd50; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel busy", {31'd0, busy}, 32'd0);
    repeat (DC) @(negedge clk);
    chk("cancel hi", hi, 32'hCAFE_0001);
    chk("cancel lo", lo, 32'd0);
    start = 1'b1; cancel = 1'b1; op = 2'd0; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("cancel start", {31'd0, busy}, 32'd0);
    we = 1'b1; hilo = 1'b0; a = 32'h0000_0077;
    @(negedge clk);
    we = 1'b0; cancel = 1'b0;
    chk("cancel idle we", lo, 32'h0000_0077);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xalu_seq.md
# xalu_seq

Multi-cycle multiply/divide sequencer owning the HI/LO register pair of the pipelined MIPS core. It accepts a mult/multu/div/divu start from the E stage, holds busy for a fixed latency, and then commits the 64-bit result to HI/LO. It also handles mthi/mtlo writes and mfhi/mflo reads, and raises the D-stage stall for any HI/LO-touching instruction while an operation is in flight.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  E stage holds mult/multu/div/divu
- op  in  2  0 multu, 1 mult, 2 divu, 3 div
- a, b  in  32 each  rs/rt operands, sampled only on accepted start
- we  in  1  E stage holds mthi/mtlo
- hilo  in  1  1 = write HI, 0 = write LO
- outsel  in  1  1 = read HI, 0 = read LO
- d_hilo_use  in  1  D stage holds any mult/div/mfhi/mflo/mthi/mtlo
- cancel  in  1  abort in-flight op; present only with XALU_CANCEL_EN
- busy  out  1  operation in flight
- stall  out  1  D-stage stall request
- out  out  32  mfhi/mflo read data
- hi, lo  out  32 each  architectural HI/LO

## Operation
- Two states: IDLE, BUSY. A down-counter holds the remaining cycles.
- IDLE with start=1:
  - latch the 64-bit result from the arithmetic unit into pending registers
  - load counter with MULT_CYCLES (op<2) or DIV_CYCLES
  - go to BUSY
- BUSY: decrement each cycle. In the cycle the counter equals 1:
  - write HI/LO from the pending registers
  - return to IDLE
- start while BUSY is ignored; the pending result is not disturbed. The stall normally prevents this case.
- we=1 in IDLE with start=0: write a into HI (hilo=1) or LO (hilo=0) at the clock edge.
- we=1 while BUSY, or in the same cycle as start, is ignored. start wins.
- Multiply results:
  - mult: signed 32×32→64, HI = upper 32 bits, LO = lower 32 bits
  - multu: unsigned 32×32→64, same split
- Divide results: LO = quotient, HI = remainder.
  - div truncates toward zero; the remainder takes the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (div and divu): LO=0xFFFFFFFF, HI=a.
- stall = d_hilo_use & (start | busy), combinational.
- out = outsel ? hi : lo, combinational from the registers. No bypass of a same-cycle we.
- Reset values:
  - state IDLE, counter 0
  - busy=0, hi=0, lo=0, pending registers=0
  - consequently out=0; stall follows its inputs (0 when start and d_hilo_use are 0)
- Reset during BUSY discards the operation and zeroes HI/LO.

## Timing
- Start accepted in cycle 0.
- busy=1 in cycles 1..N, where N = MULT_CYCLES or DIV_CYCLES.
- HI/LO take the new value on the edge closing cycle N; visible from cycle N+1, when busy=0.
- A back-to-back start is accepted in cycle N+1.
- stall is asserted in cycle 0 (via start) and in cycles 1..N. It is not asserted in cycle N+1, so an mfhi released then reads the new value.
- mthi/mtlo: one-edge latency; out reflects the write in the next cycle.

## Configuration
- XALU_CANCEL_EN defined: the cancel port exists.
  - cancel=1 in BUSY returns to IDLE on the next edge with no HI/LO write. busy=0 from the next cycle.
  - cancel=1 in the same cycle as start drops the start.
  - cancel in IDLE has no effect; we in the same cycle still proceeds.
  - Used for exception/eret flush.
- Not defined: no cancel port; every accepted operation completes.

## Structure
- Package xalu_pkg:
  - op encodings (OP_MULTU..OP_DIV)
  - state enum (IDLE, BUSY)
  - default latency constants
  - divide-by-zero result constants
- Sub-module xalu_arith: purely combinational {hi,lo} = f(op, a, b), including signed/unsigned and the divide-by-zero and overflow rules.
- xalu_seq holds the FSM, counter, pending registers, HI/LO, and the stall/out logic.

## Test plan
- mult a=0xFFFFFFFD (−3), b=5 → busy for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- multu a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- div a=0xFFFFFFF9 (−7), b=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234.
- Stall and write rules:
  - d_hilo_use=1 throughout a div → stall=1 in cycles 0..10, 0 in cycle 11.
  - we=1, hilo=1, a=0xAAAA0000 while busy → hi unchanged.
  - same write in IDLE with outsel=1 → out=0xAAAA0000 next cycle.
- reset=1 at cycle 3 of a mult → next cycle busy=0, hi=lo=0.
- With XALU_CANCEL_EN: cancel at cycle 4 of a div → busy=0 next cycle; prior HI/LO retained.
